cla_pipe_adder: RTL and testbench

Parametrised, pipelined carry-lookahead adder for the add/shift multiplier datapath and other wide-adder users. The WIDTH-bit word is split into GROUP-bit lookahead groups. Each group gets one register stage, with the inter-group carry registered between stages. This trades latency for an Fmax independent of WIDTH. Streaming valid/ready handshakes on both sides provide one result per cycle, plus word-level generate/propagate and signed-overflow flags.

---
 rtl/cla_pipe_adder.sv | 205 ++++++++++++++++++++
 tb/tb_cla_pipe_adder.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cla_pipe_adder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : cla_pipe_adder                                                  |
// | Purpose  : Pipelined carry-lookahead adder. The WIDTH-bit word is cut into |
// |            NG = WIDTH/GROUP lookahead groups. Each group is resolved in    |
// |            its own register stage, and the group carry is handed to the   |
// |            next stage through a register. One result per cycle under a    |
// |            streaming valid/ready handshake. Also reports word-level        |
// |            generate/propagate and signed overflow.                         |
// | Ports    : clk, rst (sync, active-high)                                    |
// |            in_valid/in_ready, in_a, in_b, in_cin, in_sub  - operand beat   |
// |            out_valid/out_ready, out_sum, out_cout, out_gg, out_pg,         |
// |            out_ovf                                        - result beat    |
// | Options  : `define CLA_SUB_EN to build the subtract path (in_sub = 1       |
// |            computes in_a + ~in_b + ~in_cin). When it is undefined, in_sub  |
// |            has no effect.                                                  |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module cla_pipe_adder #(
  parameter int WIDTH = 16,
  parameter int GROUP = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  input  logic             in_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_gg,
  output logic             out_pg,
  output logic             out_ovf
);

  localparam int NG = WIDTH / GROUP;

  if ((GROUP < 1) || (GROUP > 8) || ((WIDTH % GROUP) != 0)) begin : g_param_err
    $error("cla_pipe_adder: WIDTH must be a multiple of GROUP and GROUP must be 1..8");
  end

  // The only stall source is a held result. Because of that, the whole pipe
  // moves in lock-step, and a bubble advances like a beat with valid = 0.
  logic w_advance;
  assign w_advance = !(out_valid && !out_ready);
  assign in_ready  = w_advance;

  // Operands as seen by stage 0, after the optional subtract inversion.
  logic [WIDTH-1:0] w_b0;
  logic             w_cin0;
`ifdef CLA_SUB_EN
  assign w_b0   = in_b ^ {WIDTH{in_sub}};
  assign w_cin0 = in_cin ^ in_sub;
`else
  assign w_b0   = in_b;
  // in_sub has no function in this build. It is tied off so that it is not a dangling input.
  assign w_cin0 = in_cin | (in_sub & 1'b0);
`endif

  // Per-stage registers. a_q and b_q carry the operands forward to the stages
  // that have not yet consumed them. sum_q accumulates the finished low groups.
  logic             valid_q [NG];
  logic [WIDTH-1:0] a_q     [NG];
  logic [WIDTH-1:0] b_q     [NG];
  logic [WIDTH-1:0] sum_q   [NG];
  logic             cy_q    [NG];
  logic             gg_q    [NG];
  logic             pg_q    [NG];
  logic             ovf_q;

  // Stage inputs. Stage 0 takes them from the ports, and later stages take them from the previous stage.
  logic             src_v   [NG];
  logic [WIDTH-1:0] src_a   [NG];
  logic [WIDTH-1:0] src_b   [NG];
  logic [WIDTH-1:0] src_sum [NG];
  logic             src_c   [NG];
  logic             src_gg  [NG];
  logic             src_pg  [NG];

  for (genvar k = 0; k < NG; k++) begin : g_stage

    if (k == 0) begin : g_src_in
      assign src_v[k]   = in_valid;
      assign src_a[k]   = in_a;
      assign src_b[k]   = w_b0;
      assign src_sum[k] = '0;
      assign src_c[k]   = w_cin0;
      // These are the identity values of the gg/pg recurrence.
      assign src_gg[k]  = 1'b0;
      assign src_pg[k]  = 1'b1;
    end else begin : g_src_prev
      assign src_v[k]   = valid_q[k-1];
      assign src_a[k]   = a_q[k-1];
      assign src_b[k]   = b_q[k-1];
      assign src_sum[k] = sum_q[k-1];
      assign src_c[k]   = cy_q[k-1];
      assign src_gg[k]  = gg_q[k-1];
      assign src_pg[k]  = pg_q[k-1];
    end

    logic [GROUP-1:0] w_ga;
    logic [GROUP-1:0] w_gb;
    logic [GROUP-1:0] w_g;
    logic [GROUP-1:0] w_p;
    logic [GROUP-1:0] w_s;
    logic [GROUP:0]   w_c;
    logic             w_acc;
    logic             w_term;
    logic             w_grp_g;
    logic             w_grp_p;
    logic [WIDTH-1:0] w_sum_d;
    logic             w_gg_d;
    logic             w_pg_d;

    assign w_ga = src_a[k][k*GROUP +: GROUP];
    assign w_gb = src_b[k][k*GROUP +: GROUP];

    // The carry into bit i is computed as a flat sum of products:
    //   C[i] = OR_j ( g[j] & p[j+1] & ... & p[i-1] )  |  ( p[0] & ... & p[i-1] & cin )
    // No term depends on another carry, so the logic is two-level rather than a ripple chain.
    // After the final iteration (i = GROUP), w_acc holds the group generate.
    always_comb begin
      w_g     = w_ga & w_gb;
      w_p     = w_ga | w_gb;
      w_c     = '0;
      w_c[0]  = src_c[k];
      w_acc   = 1'b0;
      w_term  = 1'b0;
      for (int i = 1; i <= GROUP; i++) begin
        w_acc = 1'b0;
        for (int j = 0; j < i; j++) begin
          w_term = w_g[j];
          for (int m = j + 1; m < i; m++) begin
            w_term = w_term & w_p[m];
          end
          w_acc = w_acc | w_term;
        end
        w_term = src_c[k];
        for (int m = 0; m < i; m++) begin
          w_term = w_term & w_p[m];
        end
        w_c[i] = w_acc | w_term;
      end
      w_grp_g = w_acc;
      w_grp_p = &w_p;
      w_s     = w_ga ^ w_gb ^ w_c[GROUP-1:0];
    end

    always_comb begin
      w_sum_d                      = src_sum[k];
      w_sum_d[k*GROUP +: GROUP]    = w_s;
    end

    assign w_gg_d = w_grp_g | (w_grp_p & src_gg[k]);
    assign w_pg_d = w_grp_p & src_pg[k];

    always_ff @(posedge clk) begin
      if (rst) begin
        valid_q[k] <= 1'b0;
        a_q[k]     <= '0;
        b_q[k]     <= '0;
        sum_q[k]   <= '0;
        cy_q[k]    <= 1'b0;
        gg_q[k]    <= 1'b0;
        pg_q[k]    <= 1'b0;
      end else if (w_advance) begin
        // For stage 0, w_advance is the same signal as in_ready, so src_v[0] counts only accepted beats.
        valid_q[k] <= src_v[k];
        a_q[k]     <= src_a[k];
        b_q[k]     <= src_b[k];
        sum_q[k]   <= w_sum_d;
        cy_q[k]    <= w_c[GROUP];
        gg_q[k]    <= w_gg_d;
        pg_q[k]    <= w_pg_d;
      end
    end

    if (k == NG - 1) begin : g_last
      // Signed overflow needs the carry into the word MSB, and that carry exists only inside the top group.
      logic w_ovf_d;
      assign w_ovf_d = w_c[GROUP-1] ^ w_c[GROUP];

      always_ff @(posedge clk) begin
        if (rst) begin
          ovf_q <= 1'b0;
        end else if (w_advance) begin
          ovf_q <= w_ovf_d;
        end
      end
    end
  end

  assign out_valid = valid_q[NG-1];
  assign out_sum   = sum_q[NG-1];
  assign out_cout  = cy_q[NG-1];
  assign out_gg    = gg_q[NG-1];
  assign out_pg    = pg_q[NG-1];
  assign out_ovf   = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_cla_pipe_adder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_cla_pipe_adder                                               |
// | Purpose  : Self-checking bench for cla_pipe_adder (WIDTH=16, GROUP=4).     |
// |            An arithmetic reference model feeds a FIFO scoreboard.          |
// |            Stimulus is directed plus random, and the bench honours         |
// |            CLA_SUB_EN in the same way as the design.                       |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module tb_cla_pipe_adder;

  localparam int WIDTH = 16;
  localparam int GROUP = 4;
  localparam int NG    = WIDTH / GROUP;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             in_cin;
  logic             in_sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_sum;
  logic             out_cout;
  logic             out_gg;
  logic             out_pg;
  logic             out_ovf;

  always #5 clk = ~clk;

  cla_pipe_adder #(.WIDTH(WIDTH), .GROUP(GROUP)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_cin    (in_cin),
    .in_sub    (in_sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_cout  (out_cout),
    .out_gg    (out_gg),
    .out_pg    (out_pg),
    .out_ovf   (out_ovf)
  );

  typedef struct {
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             gg;
    logic             pg;
    logic             ovf;
  } exp_t;

  exp_t             sb[$];
  int               checks = 0;
  int               errors = 0;
  logic             accepted;
  logic             popped;
  logic [WIDTH-1:0] last_sum;
  logic             last_cout, last_gg, last_pg, last_ovf;
  logic [WIDTH-1:0] pop_log[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer addition for the sum and carry. Group
  // generate/propagate are derived from each group's own 4-bit addition,
  // and the results are folded LSB group first.
  function automatic exp_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                 input logic cin, input logic sub);
    exp_t             r;
    logic [WIDTH-1:0] bb;
    logic             cc;
    logic             do_sub;
    logic [WIDTH:0]   full;
    logic [GROUP:0]   gsum;
    logic [GROUP-1:0] ga, gb;
    logic             gacc;
`ifdef CLA_SUB_EN
    do_sub = sub;
`else
    do_sub = sub & 1'b0;
`endif
    bb = do_sub ? ~b : b;
    cc = do_sub ? ~cin : cin;
    full   = {1'b0, a} + {1'b0, bb} + {{WIDTH{1'b0}}, cc};
    r.sum  = full[WIDTH-1:0];
    r.cout = full[WIDTH];
    r.ovf  = (a[WIDTH-1] == bb[WIDTH-1]) && (full[WIDTH-1] != a[WIDTH-1]);
    r.pg   = &(a | bb);
    gacc   = 1'b0;
    for (int g = 0; g < NG; g++) begin
      ga   = a[g*GROUP +: GROUP];
      gb   = bb[g*GROUP +: GROUP];
      gsum = {1'b0, ga} + {1'b0, gb};
      gacc = gsum[GROUP] | ((&(ga | gb)) & gacc);
    end
    r.gg = gacc;
    return r;
  endfunction

  // One clock cycle. Inputs are driven at the falling edge. After a settle
  // delay, the handshakes that will occur at the next rising edge are scored.
  task automatic cycle(input logic v, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                       input logic cin, input logic sub, input logic ordy, input logic r);
    exp_t e;
    @(negedge clk);
    rst = r; in_valid = v; in_a = a; in_b = b; in_cin = cin; in_sub = sub; out_ready = ordy;
    #1;
    accepted = 1'b0;
    popped   = 1'b0;
    if (!r) begin
      if (out_valid && !out_ready) begin
        check("stall_in_ready", {31'b0, in_ready}, 32'd0);
        if (sb.size() > 0) check("stall_hold_sum", {16'b0, out_sum}, {16'b0, sb[0].sum});
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check("spurious_out", {31'b0, out_valid}, 32'd0);
        end else begin
          e = sb.pop_front();
          check("sum",  {16'b0, out_sum}, {16'b0, e.sum});
          check("cout", {31'b0, out_cout}, {31'b0, e.cout});
          check("gg",   {31'b0, out_gg},   {31'b0, e.gg});
          check("pg",   {31'b0, out_pg},   {31'b0, e.pg});
          check("ovf",  {31'b0, out_ovf},  {31'b0, e.ovf});
          last_sum = out_sum; last_cout = out_cout; last_gg = out_gg;
          last_pg = out_pg; last_ovf = out_ovf;
          pop_log.push_back(out_sum);
          popped = 1'b1;
        end
      end
      if (in_valid && in_ready) begin
        sb.push_back(model(a, b, cin, sub));
        accepted = 1'b1;
      end
    end
  endtask

  task automatic idle(input logic ordy);
    cycle(1'b0, '0, '0, 1'b0, 1'b0, ordy, 1'b0);
  endtask

  // Reset for n cycles while offering a beat, which must not be taken. Then
  // check the reset values in the first cycle after release.
  task automatic do_reset(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      cycle(1'b1, WIDTH'($urandom), WIDTH'($urandom), 1'b0, 1'b0, 1'b1, 1'b1);
    end
    sb.delete();
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    #1;
    check({tag, "_out_valid"}, {31'b0, out_valid}, 32'd0);
    check({tag, "_out_sum"},   {16'b0, out_sum},   32'd0);
    check({tag, "_out_cout"},  {31'b0, out_cout},  32'd0);
    check({tag, "_out_gg"},    {31'b0, out_gg},    32'd0);
    check({tag, "_out_pg"},    {31'b0, out_pg},    32'd0);
    check({tag, "_out_ovf"},   {31'b0, out_ovf},   32'd0);
    check({tag, "_in_ready"},  {31'b0, in_ready},  32'd1);
  endtask

  // Single beat into an empty pipe. Checks the latency and the spec's fixed expected values.
  task automatic single(input string tag, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic cin, input logic sub, input logic [WIDTH-1:0] x_sum,
                        input logic x_cout, input logic x_ovf, input logic x_gg, input logic x_pg,
                        input logic chk_gp);
    int lat;
    cycle(1'b1, a, b, cin, sub, 1'b1, 1'b0);
    check({tag, "_accept"}, {31'b0, accepted}, 32'd1);
    lat = 0;
    popped = 1'b0;
    while (!popped && lat < 20) begin
      idle(1'b1);
      lat++;
    end
    check({tag, "_latency"}, lat, NG);
    check({tag, "_sum"},  {16'b0, last_sum}, {16'b0, x_sum});
    check({tag, "_cout"}, {31'b0, last_cout}, {31'b0, x_cout});
    check({tag, "_ovf"},  {31'b0, last_ovf},  {31'b0, x_ovf});
    if (chk_gp) begin
      check({tag, "_gg"}, {31'b0, last_gg}, {31'b0, x_gg});
      check({tag, "_pg"}, {31'b0, last_pg}, {31'b0, x_pg});
    end
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while (sb.size() > 0 && n < 50) begin
      idle(1'b1);
      n++;
    end
    check({tag, "_drained"}, sb.size(), 0);
  endtask

  initial begin
    int idx;
    int cyc;
    logic [WIDTH-1:0] ra, rb;
    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_cin = 1'b0; in_sub = 1'b0;
    out_ready = 1'b0;
    last_sum = '0; last_cout = 1'b0; last_gg = 1'b0; last_pg = 1'b0; last_ovf = 1'b0;
    accepted = 1'b0; popped = 1'b0;

    do_reset(3, "reset");

    // Directed arithmetic cases
    single("basic",  16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    single("chain",  16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
    single("ovf",    16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
`ifdef CLA_SUB_EN
    single("sub",    16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
`else
    single("sub",    16'h0005, 16'h0007, 1'b0, 1'b1, 16'h000C, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
`endif

    // Backpressure: 8 beats A=B=i, out_ready low for cycles 6..8; a beat is held until taken
    pop_log.delete();
    idx = 0;
    cyc = 0;
    while ((idx < 8 || sb.size() > 0) && cyc < 60) begin
      cycle(idx < 8, WIDTH'(idx), WIDTH'(idx), 1'b0, 1'b0, !(cyc >= 6 && cyc <= 8), 1'b0);
      if (cyc >= 6 && cyc <= 8) check("bp_out_valid_hold", {31'b0, out_valid}, 32'd1);
      if (accepted) idx++;
      cyc++;
    end
    check("bp_count", pop_log.size(), 8);
    for (int i = 0; i < 8 && i < pop_log.size(); i++) begin
      check($sformatf("bp_order%0d", i), {16'b0, pop_log[i]}, 2 * i);
    end

    // Reset flush: three beats in flight are discarded
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, WIDTH'(16'h1111 * (i + 1)), WIDTH'(16'h0101), 1'b0, 1'b0, 1'b1, 1'b0);
    end
    do_reset(1, "flush");
    for (int i = 0; i < 8; i++) idle(1'b1);
    single("post_flush", 16'h0001, 16'h0001, 1'b0, 1'b0, 16'h0002, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Random traffic with random handshakes and operand extremes
    for (int i = 0; i < 600; i++) begin
      case ($urandom_range(0, 3))
        0:       ra = 16'hFFFF;
        1:       ra = 16'h7FFF;
        default: ra = WIDTH'($urandom);
      endcase
      rb = ($urandom_range(0, 3) == 0) ? WIDTH'($urandom_range(0, 3)) : WIDTH'($urandom);
      cycle($urandom_range(0, 3) != 0, ra, rb, 1'($urandom), 1'($urandom),
            $urandom_range(0, 3) != 0, 1'b0);
    end
    drain("random");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
